alu_issue_arbiter: RTL

Shares one combinational ALU among `PORTCOUNT` requesters, such as the integer issue slots and the address-generation helper. It arbitrates ready/valid requests and registers the winning operation into an issue stage that drives the ALU. It then captures the ALU result into a response register that is returned with the requester ID. It sits between the issue logic and the ALU datapath and sustains one operation per cycle when there is no backpressure.

---
 rtl/alu_issue_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/alu_issue_arbiter.sv
// Shares one ALU among PORTCOUNT requesters; ALU_ARBITER_RR_EN selects round-robin, else fixed priority.
// Latency 2 cycles accept->Resp_Valid; Resp_Ready low with both stages full drops all Req_Ready.
module alu_issue_arbiter #(
    parameter int BITWIDTH = 16,
    parameter int PORTCOUNT = 4,
    localparam int IDWIDTH = $clog2(PORTCOUNT)
) (
    input  logic                          clk,
    input  logic                          sync_rst,
    input  logic [PORTCOUNT-1:0]          Req_Valid,
    output logic [PORTCOUNT-1:0]          Req_Ready,
    input  logic [4*PORTCOUNT-1:0]        Req_Opcode,
    input  logic [BITWIDTH*PORTCOUNT-1:0] Req_DataA,
    input  logic [BITWIDTH*PORTCOUNT-1:0] Req_DataB,
    output logic                          ALU_Enable,
    output logic [3:0]                    ALU_Opcode,
    output logic [BITWIDTH-1:0]           ALU_DataA,
    output logic [BITWIDTH-1:0]           ALU_DataB,
    input  logic [BITWIDTH-1:0]           ALU_Result,
    output logic                          Resp_Valid,
    input  logic                          Resp_Ready,
    output logic [IDWIDTH-1:0]            Resp_ID,
    output logic [BITWIDTH-1:0]           Resp_Data
);

    localparam int IW1 = IDWIDTH + 1;

    logic                 s1_vld;
    logic [IDWIDTH-1:0]   s1_id;
    logic [3:0]           s1_op;
    logic [BITWIDTH-1:0]  s1_a;
    logic [BITWIDTH-1:0]  s1_b;

    logic                 s2_vld;
    logic [IDWIDTH-1:0]   s2_id;
    logic [BITWIDTH-1:0]  s2_dat;

    logic                 s2_load;
    logic                 s1_free;
    logic                 accept;
    logic [PORTCOUNT-1:0] grant;
    logic [IDWIDTH-1:0]   grant_id;
    logic [3:0]           sel_op;
    logic [BITWIDTH-1:0]  sel_a;
    logic [BITWIDTH-1:0]  sel_b;

`ifdef ALU_ARBITER_RR_EN
    logic [IDWIDTH-1:0]   ptr;
`endif

    assign s2_load = s1_vld & (~s2_vld | Resp_Ready);
    assign s1_free = ~s1_vld | s2_load;

    always_comb begin
        logic               found;
        logic [IW1-1:0]     sum;
        logic [IDWIDTH-1:0] idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int k = 0; k < PORTCOUNT; k++) begin
`ifdef ALU_ARBITER_RR_EN
            // Search begins at the pointer and wraps modulo PORTCOUNT.
            sum = {1'b0, ptr} + IW1'(k);
            if (sum >= IW1'(PORTCOUNT)) begin
                sum = sum - IW1'(PORTCOUNT);
            end
`else
            sum = IW1'(k);
`endif
            idx = sum[IDWIDTH-1:0];
            if (!found && Req_Valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < PORTCOUNT; i++) begin
            if (grant[i]) begin
                sel_op = Req_Opcode[4*i +: 4];
                sel_a  = Req_DataA[BITWIDTH*i +: BITWIDTH];
                sel_b  = Req_DataB[BITWIDTH*i +: BITWIDTH];
            end
        end
    end

    // Reset is folded in so no requester sees an accept that reset would discard.
    assign Req_Ready = grant & {PORTCOUNT{s1_free & ~sync_rst}};
    assign accept    = |(Req_Valid & Req_Ready);

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            s1_vld <= 1'b0;
            s1_id  <= '0;
            s1_op  <= '0;
            s1_a   <= '0;
            s1_b   <= '0;
        end else if (s1_free) begin
            s1_vld <= accept;
            if (accept) begin
                s1_id <= grant_id;
                s1_op <= sel_op;
                s1_a  <= sel_a;
                s1_b  <= sel_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            s2_vld <= 1'b0;
            s2_id  <= '0;
            s2_dat <= '0;
        end else if (s2_load) begin
            s2_vld <= 1'b1;
            s2_id  <= s1_id;
            s2_dat <= ALU_Result;
        end else if (s2_vld && Resp_Ready) begin
            s2_vld <= 1'b0;
        end
    end

`ifdef ALU_ARBITER_RR_EN
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            ptr <= '0;
        end else if (accept) begin
            if (grant_id == IDWIDTH'(PORTCOUNT - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_id + 1'b1;
            end
        end
    end
`endif

    assign ALU_Enable = s1_vld;
    assign ALU_Opcode = s1_op;
    assign ALU_DataA  = s1_a;
    assign ALU_DataB  = s1_b;
    assign Resp_Valid = s2_vld;
    assign Resp_ID    = s2_id;
    assign Resp_Data  = s2_dat;

    a_ready_onehot: assert property (@(posedge clk) $onehot0(Req_Ready));
    a_resp_hold: assert property (@(posedge clk) disable iff (sync_rst)
        (Resp_Valid && !Resp_Ready) |=> (Resp_Valid && $stable(Resp_ID) && $stable(Resp_Data)));

endmodule
